// File: rtl/reg_file_modal_pkg.sv
// Shared types for the moded register file: per-register access modes and
// the response-stage state.
package reg_file_modal_pkg;

  typedef enum logic [1:0] {
    RW  = 2'd0,
    RO  = 2'd1,
    W1C = 2'd2,
    W1S = 2'd3
  } reg_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rsp_state_e;

  // Index width that stays legal for a single-register file.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_file_modal_cell.sv
// One register with its mode-dependent next-state logic and bus/hw priority.
// The rst input is active-low and asynchronous.
module reg_file_modal_cell
  import reg_file_modal_pkg::*;
#(
  parameter int unsigned RegWidth = 32,
  parameter reg_mode_e   Mode     = RW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RegWidth-1:0] rst_val,
  input  logic                bus_we,
  input  logic [RegWidth-1:0] mask,
  input  logic [RegWidth-1:0] wdata,
  input  logic                hw_we,
  input  logic [RegWidth-1:0] hw_d,
  output logic [RegWidth-1:0] q
);

  logic [RegWidth-1:0] bus_bits;
  logic [RegWidth-1:0] hw_bits;
  logic [RegWidth-1:0] q_next;

  assign bus_bits = bus_we ? (wdata & mask) : '0;
  assign hw_bits  = hw_we ? hw_d : '0;

  always_comb begin
    q_next = q;
    unique case (Mode)
      RW: begin
        if (hw_we) q_next = hw_d;
        if (bus_we) q_next = (q_next & ~mask) | (wdata & mask);
      end
      RO:  q_next = hw_we ? hw_d : q;
      // Sticky events: a hw set in the same cycle as a bus clear survives.
      W1C: q_next = (q & ~bus_bits) | hw_bits;
      W1S: q_next = (q & ~hw_bits) | bus_bits;
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= rst_val;
    else      q <= q_next;
  end

endmodule

// File: rtl/reg_file_modal.sv
// Register file on the register bus with per-register access modes, hw update
// ports and an optional registered response stage.
module reg_file_modal
  import reg_file_modal_pkg::*;
#(
  parameter int unsigned              AddrWidth  = 32,
  parameter int unsigned              DataWidth  = 32,
  parameter int unsigned              NumReg     = 8,
  parameter int unsigned              RegWidth   = 32,
  parameter reg_mode_e [NumReg-1:0]   RegMode    = '0,
  parameter int unsigned              RspLatency = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReg*RegWidth-1:0]    rst_val_i,
  input  logic                          reg_valid_i,
  output logic                          reg_ready_o,
  input  logic                          reg_write_i,
  input  logic [AddrWidth-1:0]          reg_addr_i,
  input  logic [DataWidth-1:0]          reg_wdata_i,
  input  logic [DataWidth/8-1:0]        reg_wstrb_i,
  output logic [DataWidth-1:0]          reg_rdata_o,
  output logic                          reg_error_o,
  input  logic [NumReg-1:0]             hw_we_i,
  input  logic [NumReg*RegWidth-1:0]    hw_d_i,
  output logic [NumReg*RegWidth-1:0]    q_o,
  output logic [NumReg-1:0]             wr_evt_o
);

  localparam int unsigned WordBytes = DataWidth / 8;
  localparam int unsigned OffBits   = (WordBytes > 1) ? $clog2(WordBytes) : 0;
  localparam int unsigned IdxWidth  = idx_width(NumReg);

  logic [AddrWidth-1:0] word;
  logic                 in_range;
  logic [NumReg-1:0]    sel;
  logic [NumReg-1:0]    ro_map;
  logic [NumReg-1:0]    bus_we;
  logic [RegWidth-1:0]  mask;
  logic [RegWidth-1:0]  q_arr [NumReg];
  logic                 idle;
  logic                 accept;
  logic                 req_err;
  logic [DataWidth-1:0] rd_word;
  logic [NumReg-1:0]    wr_evt_reg;

  assign word     = reg_addr_i >> OffBits;
  assign in_range = (word < AddrWidth'(NumReg));
  assign accept   = reg_valid_i && idle;

  genvar gi;

  for (gi = 0; gi < RegWidth / 8; gi++) begin : g_mask
    assign mask[8*gi +: 8] = {8{reg_wstrb_i[gi]}};
  end

  for (gi = 0; gi < NumReg; gi++) begin : g_reg
    assign sel[gi]    = in_range && (word == AddrWidth'(gi));
    assign ro_map[gi] = (RegMode[gi] == RO);
    // Writes to RO registers are rejected, so they never reach the cell.
    assign bus_we[gi] = accept && reg_write_i && sel[gi] && !ro_map[gi];

    reg_file_modal_cell #(
      .RegWidth (RegWidth),
      .Mode     (RegMode[gi])
    ) u_cell (
      .clk     (clk_i),
      .rst     (rst_ni),
      .rst_val (rst_val_i[gi*RegWidth +: RegWidth]),
      .bus_we  (bus_we[gi]),
      .mask    (mask),
      .wdata   (reg_wdata_i[RegWidth-1:0]),
      .hw_we   (hw_we_i[gi]),
      .hw_d    (hw_d_i[gi*RegWidth +: RegWidth]),
      .q       (q_arr[gi])
    );

    assign q_o[gi*RegWidth +: RegWidth] = q_arr[gi];
  end

  assign req_err = !in_range || (reg_write_i && |(sel & ro_map));

  always_comb begin
    rd_word = '0;
    if (!reg_write_i && in_range) rd_word[RegWidth-1:0] = q_arr[word[IdxWidth-1:0]];
  end

  // Pulse includes zero-strobe writes: the commit itself is the event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wr_evt_reg <= '0;
    else         wr_evt_reg <= bus_we;
  end
  assign wr_evt_o = wr_evt_reg;

  if (RspLatency == 0) begin : g_comb_rsp
    assign idle        = 1'b1;
    assign reg_ready_o = reg_valid_i;
    assign reg_rdata_o = rd_word;
    assign reg_error_o = req_err;
  end else begin : g_reg_rsp
    rsp_state_e           state_reg;
    logic                 ready_reg;
    logic                 error_reg;
    logic [DataWidth-1:0] rdata_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_reg <= IDLE;
        ready_reg <= 1'b0;
        error_reg <= 1'b0;
        rdata_reg <= '0;
      end else begin
        unique case (state_reg)
          IDLE: if (reg_valid_i) begin
            state_reg <= RESP;
            ready_reg <= 1'b1;
            error_reg <= req_err;
            rdata_reg <= rd_word;
          end
          RESP: begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
            error_reg <= 1'b0;
            rdata_reg <= '0;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end

    assign idle        = (state_reg == IDLE);
    assign reg_ready_o = ready_reg;
    assign reg_rdata_o = rdata_reg;
    assign reg_error_o = error_reg;
  end

endmodule

// File: tb/tb_reg_file_modal.sv
// Bench for reg_file_modal: two instances (combinational and registered response),
// directed table, randomized traffic against a bit-level reference model, reset-in-RESP.
module tb_reg_file_modal;
  import reg_file_modal_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n  [2];
  logic         valid  [2];
  logic         write  [2];
  logic [31:0]  addr   [2];
  logic [31:0]  wdata  [2];
  logic [3:0]   wstrb  [2];
  logic         ready  [2];
  logic [31:0]  rdata  [2];
  logic         error  [2];
  logic [3:0]   hw_we  [2];
  logic [127:0] hw_d   [2];
  logic [127:0] q      [2];
  logic [3:0]   wr_evt [2];
  logic [127:0] rst_val;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [2][4];

  reg_file_modal #(
    .AddrWidth(32), .DataWidth(32), .NumReg(4), .RegWidth(32),
    .RegMode({W1S, W1C, RO, RW}), .RspLatency(0)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .rst_val_i(rst_val),
    .reg_valid_i(valid[0]), .reg_ready_o(ready[0]), .reg_write_i(write[0]),
    .reg_addr_i(addr[0]), .reg_wdata_i(wdata[0]), .reg_wstrb_i(wstrb[0]),
    .reg_rdata_o(rdata[0]), .reg_error_o(error[0]),
    .hw_we_i(hw_we[0]), .hw_d_i(hw_d[0]), .q_o(q[0]), .wr_evt_o(wr_evt[0])
  );

  reg_file_modal #(
    .AddrWidth(32), .DataWidth(32), .NumReg(4), .RegWidth(32),
    .RegMode({W1S, W1C, RO, RW}), .RspLatency(1)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .rst_val_i(rst_val),
    .reg_valid_i(valid[1]), .reg_ready_o(ready[1]), .reg_write_i(write[1]),
    .reg_addr_i(addr[1]), .reg_wdata_i(wdata[1]), .reg_wstrb_i(wstrb[1]),
    .reg_rdata_o(rdata[1]), .reg_error_o(error[1]),
    .hw_we_i(hw_we[1]), .hw_d_i(hw_d[1]), .q_o(q[1]), .wr_evt_o(wr_evt[1])
  );

  typedef struct {
    bit          en;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  hwe;
    logic [31:0] hwd;
    int          reg_i;
    logic [31:0] exp_q;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [15];

  function automatic reg_mode_e mode_of(int i);
    case (i)
      0:       return RW;
      1:       return RO;
      2:       return W1C;
      default: return W1S;
    endcase
  endfunction

  function automatic logic [127:0] model_vec(int l);
    return {mdl[l][3], mdl[l][2], mdl[l][1], mdl[l][0]};
  endfunction

  task automatic model_reset(int l);
    for (int i = 0; i < 4; i++) mdl[l][i] = rst_val[32*i +: 32];
  endtask

  task automatic chk(int l, string name, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL lat%0d %s: got=%0h expected=%0h", l, name, got, exp);
    end
  endtask

  // Reference: applies one cycle of bus + hw activity bit by bit.
  task automatic model_step(int l, bit en, bit wr, logic [31:0] a, logic [31:0] d,
                            logic [3:0] s, logic [3:0] hwe, logic [127:0] hwd,
                            output bit e_err, output logic [31:0] e_rd,
                            output logic [3:0] e_evt);
    int          w;
    bit          inr, hit, m, bb, hb;
    logic [31:0] nv, hv;
    w     = int'(a >> 2);
    inr   = (w < 4);
    e_err = en && (!inr || (wr && mode_of(w) == RO));
    e_rd  = '0;
    if (en && !wr && inr) e_rd = mdl[l][w];
    e_evt = '0;
    for (int i = 0; i < 4; i++) begin
      hit = en && wr && !e_err && (w == i);
      if (hit) e_evt[i] = 1'b1;
      nv = mdl[l][i];
      hv = hwd[32*i +: 32];
      for (int b = 0; b < 32; b++) begin
        m  = s[b/8];
        bb = hit && m && d[b];
        hb = hwe[i] && hv[b];
        case (mode_of(i))
          RW:  if (hit && m) nv[b] = d[b]; else if (hwe[i]) nv[b] = hv[b];
          RO:  if (hwe[i]) nv[b] = hv[b];
          W1C: if (hb) nv[b] = 1'b1; else if (bb) nv[b] = 1'b0;
          default: if (bb) nv[b] = 1'b1; else if (hb) nv[b] = 1'b0;
        endcase
      end
      mdl[l][i] = nv;
    end
  endtask

  task automatic step(int l, bit en, bit wr, logic [31:0] a, logic [31:0] d,
                      logic [3:0] s, logic [3:0] hwe, logic [127:0] hwd,
                      output logic [31:0] got_rd, output logic got_err);
    bit          e_err;
    logic [31:0] e_rd;
    logic [3:0]  e_evt;
    @(negedge clk);
    valid[l] = en; write[l] = wr; addr[l] = a; wdata[l] = d; wstrb[l] = s;
    hw_we[l] = hwe; hw_d[l] = hwd;
    model_step(l, en, wr, a, d, s, hwe, hwd, e_err, e_rd, e_evt);
    got_rd  = '0;
    got_err = 1'b0;
    #1;
    if (l == 0) begin
      chk(l, "ready_comb", ready[0], en);
      got_rd  = rdata[0];
      got_err = error[0];
    end else begin
      chk(l, "ready_before_accept", ready[1], 1'b0);
    end
    @(posedge clk); #1;
    if (l == 1) begin
      chk(l, "ready_resp", ready[1], en);
      got_rd  = rdata[1];
      got_err = error[1];
    end
    if (en) begin
      chk(l, "error", got_err, e_err);
      if (!wr) chk(l, "rdata", got_rd, e_rd);
    end
    chk(l, "q", q[l], model_vec(l));
    chk(l, "wr_evt", wr_evt[l], e_evt);
    @(negedge clk);
    valid[l] = 1'b0;
    hw_we[l] = '0;
    @(posedge clk); #1;
    chk(l, "ready_idle", ready[l], 1'b0);
    chk(l, "wr_evt_once", wr_evt[l], 4'h0);
    $display("txn lat%0d en=%0d wr=%0d addr=%h wdata=%h strb=%b hwe=%b rd=%h err=%0d q=%h",
             l, en, wr, a, d, s, hwe, got_rd, got_err, q[l]);
  endtask

  initial begin
    logic [31:0]  rd;
    logic         er;
    bit           en, wr;
    logic [31:0]  a;
    logic [3:0]   hwe;

    rst_val = {32'h0000_0000, 32'h0000_000F, 32'h1234_5678, 32'hA5A5_A5A5};
    for (int l = 0; l < 2; l++) begin
      rst_n[l] = 1'b0; valid[l] = 1'b0; write[l] = 1'b0; addr[l] = '0;
      wdata[l] = '0; wstrb[l] = '0; hw_we[l] = 4'hF; hw_d[l] = '1;
    end
    valid[0] = 1'b1;

    //             en    wr    addr   wdata         strb    hwe     hwd           reg exp_q         err   exp_rd
    tbl[0]  = '{1'b1, 1'b1, 32'h0,  32'h11223344, 4'b0101, 4'b0000, 32'h0,        0, 32'hA522A544, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,  32'h0,        4'b0000, 4'b0000, 32'h0,        0, 32'hA522A544, 1'b0, 32'hA522A544};
    tbl[2]  = '{1'b1, 1'b1, 32'h4,  32'hFFFFFFFF, 4'b1111, 4'b0000, 32'h0,        1, 32'h12345678, 1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h40, 32'h0,        4'b0000, 4'b0000, 32'h0,        0, 32'hA522A544, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h4,  32'h0,        4'b0000, 4'b0000, 32'h0,        1, 32'h12345678, 1'b0, 32'h12345678};
    tbl[5]  = '{1'b1, 1'b1, 32'h8,  32'h3,        4'b1111, 4'b0100, 32'h1,        2, 32'h0000000D, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 32'hC,  32'h80,       4'b0001, 4'b1000, 32'h80,       3, 32'h00000080, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,  32'h0,        4'b0000, 4'b1000, 32'h80,       3, 32'h00000000, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  32'h0,        4'b0000, 4'b0001, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  32'h0,        4'b0000, 4'b0010, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 32'h0,  32'hFFFFFFFF, 4'b0000, 4'b0000, 32'h0,        0, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 32'h0,  32'h00FF00FF, 4'b1100, 4'b0001, 32'h12345678, 0, 32'h00FF5678, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h3,  32'h0,        4'b0000, 4'b0000, 32'h0,        0, 32'h00FF5678, 1'b0, 32'h00FF5678};
    tbl[13] = '{1'b1, 1'b0, 32'h10, 32'h0,        4'b0000, 4'b0000, 32'h0,        0, 32'h00FF5678, 1'b1, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b1111, 4'b0000, 32'h0,        0, 32'h00FF5678, 1'b1, 32'h0};

    // Reset: values load, hw strobes ignored, response outputs quiet.
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      chk(l, "rst_q", q[l], rst_val);
      chk(l, "rst_wr_evt", wr_evt[l], 4'h0);
    end
    chk(0, "rst_ready_follows_valid", ready[0], 1'b1);
    chk(1, "rst_ready", ready[1], 1'b0);
    chk(1, "rst_rdata", rdata[1], 32'h0);
    chk(1, "rst_error", error[1], 1'b0);
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      rst_n[l] = 1'b1; valid[l] = 1'b0; hw_we[l] = '0;
      model_reset(l);
    end

    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < 15; k++) begin
        step(l, tbl[k].en, tbl[k].wr, tbl[k].addr, tbl[k].wdata, tbl[k].wstrb,
             tbl[k].hwe, {4{tbl[k].hwd}}, rd, er);
        chk(l, $sformatf("tbl%0d_q", k), q[l][32*tbl[k].reg_i +: 32], tbl[k].exp_q);
        if (tbl[k].en) chk(l, $sformatf("tbl%0d_err", k), er, tbl[k].exp_err);
        if (tbl[k].en && !tbl[k].wr) chk(l, $sformatf("tbl%0d_rd", k), rd, tbl[k].exp_rd);
      end
    end

    for (int l = 0; l < 2; l++) begin
      for (int n = 0; n < 150; n++) begin
        en  = ($urandom_range(0, 3) != 0);
        wr  = ($urandom_range(0, 1) == 1);
        a   = 32'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
        hwe = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        step(l, en, wr, a, $urandom, 4'($urandom_range(0, 15)), hwe,
             {$urandom, $urandom, $urandom, $urandom}, rd, er);
      end
    end

    // Reset while the registered response is pending: response dropped,
    // committed write overwritten by the reset value.
    @(negedge clk);
    valid[1] = 1'b1; write[1] = 1'b1; addr[1] = 32'h0; wdata[1] = 32'h0; wstrb[1] = 4'hF;
    @(posedge clk);
    #1 rst_n[1] = 1'b0;
    #1;
    chk(1, "rstresp_ready", ready[1], 1'b0);
    chk(1, "rstresp_q", q[1], rst_val);
    chk(1, "rstresp_wr_evt", wr_evt[1], 4'h0);
    @(negedge clk);
    valid[1] = 1'b0;
    model_reset(1);
    repeat (2) begin
      @(posedge clk); #1;
      chk(1, "rstresp_ready_held", ready[1], 1'b0);
    end
    @(negedge clk);
    rst_n[1] = 1'b1;
    step(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 128'h0, rd, er);
    chk(1, "rstresp_fresh_read", rd, 32'hA5A5A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
